// File: rtl/rnbip_pkg.sv
// rnbip_pkg: shared definitions for the RNBIP fetch stage.
// - NOP opcode constant
// - match patterns for the opcode classes that carry an operand byte
// - fetch FSM state enum
// - is_two_byte(): instruction length decode, reused by the disassembler model
package rnbip_pkg;

  localparam logic [7:0] NOP = 8'h00;

  // Two-byte classes: exact codes plus masked patterns (mask, value).
  localparam logic [7:0] OP_JUD    = 8'h03;
  localparam logic [7:0] OP_CUD    = 8'h05;
  localparam logic [7:0] JCD_MASK  = 8'hF8;
  localparam logic [7:0] JCD_VAL   = 8'h08;
  localparam logic [7:0] MVI_MASK  = 8'hF8;
  localparam logic [7:0] MVI_VAL   = 8'h58;
  localparam logic [7:0] ALUI_MASK = 8'h88;
  localparam logic [7:0] ALUI_VAL  = 8'h88;

  typedef enum logic [1:0] {
    S_OP    = 2'd0,
    S_OD    = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic is_two_byte(input logic [7:0] op);
    return (op == OP_JUD) ||
           (op == OP_CUD) ||
           ((op & JCD_MASK)  == JCD_VAL) ||
           ((op & MVI_MASK)  == MVI_VAL) ||
           ((op & ALUI_MASK) == ALUI_VAL);
  endfunction

endpackage

// File: rtl/rnbip_fetch_unit_if.sv
// rnbip_fetch_unit_if: program-memory, redirect and issue signals of the
// fetch stage.
// - master: fetch unit (drives imem_addr and the issued instruction)
// - slave : environment (program memory, control stage redirect/stall)
interface rnbip_fetch_unit_if #(
  parameter int AW = 8
);
  import rnbip_pkg::*;

  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_data;
  logic          stall;
  logic          l_pc;
  logic [AW-1:0] pc_target;
  logic [7:0]    opcode_out;
  logic [7:0]    operand_out;
  logic          instr_valid;
  logic [AW-1:0] ret_addr;

  modport master (
    output imem_addr, opcode_out, operand_out, instr_valid, ret_addr,
    input  imem_data, stall, l_pc, pc_target
  );

  modport slave (
    input  imem_addr, opcode_out, operand_out, instr_valid, ret_addr,
    output imem_data, stall, l_pc, pc_target
  );

endinterface

// File: rtl/rnbip_len_decode.sv
// rnbip_len_decode: combinational instruction-length decode.
// - opcode   in  8  first byte of an instruction
// - two_byte out 1  instruction carries an operand byte
module rnbip_len_decode
  import rnbip_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       two_byte
);

  assign two_byte = is_two_byte(opcode);

endmodule

// File: rtl/rnbip_fetch_unit.sv
// rnbip_fetch_unit: instruction fetch stage of the RNBIP pipeline.
// Fetches 1- or 2-byte instructions from program memory, issues them with
// registered outputs, and inserts NOP bubbles after a PC redirect.
// Ports:
// - clk, rst_n : clock, async active-low reset
// - bus        : rnbip_fetch_unit_if.master (imem_addr/imem_data, stall,
//                l_pc/pc_target, opcode_out/operand_out/instr_valid/ret_addr)
//
// state   | meaning
// S_OP    | fetching the first (opcode) byte
// S_OD    | fetching the operand byte of a 2-byte instruction
// S_FLUSH | post-redirect bubbles, no fetch, PC held
module rnbip_fetch_unit
  import rnbip_pkg::*;
#(
  parameter int            AW            = 8,
  parameter logic [AW-1:0] RESET_PC      = '0,
  parameter int            FLUSH_BUBBLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  rnbip_fetch_unit_if.master  bus
);

  // Counter only ever holds FLUSH_BUBBLES-1 down to 0.
  localparam int            BW       = (FLUSH_BUBBLES > 1) ? $clog2(FLUSH_BUBBLES) : 1;
  localparam logic [BW-1:0] BUB_INIT = BW'(FLUSH_BUBBLES - 1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [BW-1:0] bub_q, bub_d;
  logic [7:0]    op_latch_q, op_latch_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [7:0]    operand_q, operand_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] ret_q, ret_d;

  logic          two_byte;
  logic [AW-1:0] pc_inc;

  rnbip_len_decode u_len_decode (
    .opcode   (bus.imem_data),
    .two_byte (two_byte)
  );

  assign pc_inc = pc_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    bub_d      = bub_q;
    op_latch_d = op_latch_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    valid_d    = valid_q;
    ret_d      = ret_q;

    if (bus.l_pc) begin
      // Redirect wins over stall and drops any half-fetched instruction.
      pc_d      = bus.pc_target;
      opcode_d  = NOP;
      operand_d = 8'h00;
      valid_d   = 1'b0;
      bub_d     = BUB_INIT;
      state_d   = (BUB_INIT != '0) ? S_FLUSH : S_OP;
    end else if (!bus.stall) begin
      case (state_q)
        S_OP: begin
          pc_d = pc_inc;
          if (two_byte) begin
            op_latch_d = bus.imem_data;
            opcode_d   = NOP;
            operand_d  = 8'h00;
            valid_d    = 1'b0;
            state_d    = S_OD;
          end else begin
            opcode_d  = bus.imem_data;
            operand_d = 8'h00;
            valid_d   = 1'b1;
            ret_d     = pc_inc;
          end
        end
        S_OD: begin
          opcode_d  = op_latch_q;
          operand_d = bus.imem_data;
          valid_d   = 1'b1;
          ret_d     = pc_inc;
          pc_d      = pc_inc;
          state_d   = S_OP;
        end
        S_FLUSH: begin
          opcode_d  = NOP;
          operand_d = 8'h00;
          valid_d   = 1'b0;
          bub_d     = (bub_q == '0) ? '0 : bub_q - BW'(1);
          if (bub_q <= BW'(1)) begin
            state_d = S_OP;
          end
        end
        default: begin
          state_d = S_OP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OP;
      pc_q       <= RESET_PC;
      bub_q      <= '0;
      op_latch_q <= NOP;
      opcode_q   <= NOP;
      operand_q  <= 8'h00;
      valid_q    <= 1'b0;
      ret_q      <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bub_q      <= bub_d;
      op_latch_q <= op_latch_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      valid_q    <= valid_d;
      ret_q      <= ret_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.opcode_out  = opcode_q;
  assign bus.operand_out = operand_q;
  assign bus.instr_valid = valid_q;
  assign bus.ret_addr    = ret_q;

endmodule
